romcode_bram_arb: RTL and testbench

//  Shares the single romcode BRAM port between two requesters: req 0 = spiflash

---
 rtl/romcode_bram_arb_if.sv | 40 ++++
 rtl/romcode_bram_arb.sv | 124 ++++++++++++
 tb/tb_romcode_bram_arb.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/romcode_bram_arb_if.sv
// Bus bundle between the two romcode BRAM requesters, the BRAM port and the arbiter.
// The master side is the requesters plus the BRAM; the slave side is the arbiter.
interface romcode_bram_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          sf_lock;
  logic          req0;
  logic          req1;
  logic [3:0]    we0;
  logic [3:0]    we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          busy;

  modport master (
    output sf_lock, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_dout,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  bram_en, bram_we, bram_addr, bram_din, busy
  );

  modport slave (
    input  sf_lock, req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, bram_dout,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output bram_en, bram_we, bram_addr, bram_din, busy
  );
endinterface

// File: rtl/romcode_bram_arb.sv
// Two-requester arbiter for the single romcode BRAM port: spiflash responder (req 0)
// and host loader (req 1), with a spiflash lock that keeps the loader off the BRAM.
module romcode_bram_arb #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0
) (
  input logic               ap_clk,
  input logic               ap_rst,
  romcode_bram_arb_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t        state_r;
  logic          last_r;
  logic          owner_r;
  logic          gnt0_r;
  logic          gnt1_r;
  logic          rvalid0_r;
  logic          rvalid1_r;
  logic          en_r;
  logic [3:0]    we_r;
  logic [AW-1:0] addr_r;
  logic [DW-1:0] din_r;
  logic          busy_r;

  logic          elig0_s;
  logic          elig1_s;
  logic          pick1_s;
  logic          any_s;

  // Winner selection; last_r = 1 means the loader was granted most recently.
  always_comb begin
    elig0_s = bus.req0;
    elig1_s = bus.req1 & ~bus.sf_lock;
    any_s   = elig0_s | elig1_s;
    if (ARB_MODE == 0) begin
      pick1_s = elig1_s & (~elig0_s | ~last_r);
    end else begin
      pick1_s = elig1_s & ~elig0_s;
    end
  end

  // Access FSM; all bus-facing outputs are registered here.
  always_ff @(posedge ap_clk or negedge ap_rst) begin
    if (!ap_rst) begin
      state_r   <= IDLE;
      last_r    <= 1'b1;
      owner_r   <= 1'b0;
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      en_r      <= 1'b0;
      we_r      <= 4'h0;
      addr_r    <= {AW{1'b0}};
      din_r     <= {DW{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, RSP: begin
          rvalid0_r <= 1'b0;
          rvalid1_r <= 1'b0;
          if (any_s) begin
            state_r <= ACC;
            busy_r  <= 1'b1;
            en_r    <= 1'b1;
            gnt0_r  <= ~pick1_s;
            gnt1_r  <= pick1_s;
            owner_r <= pick1_s;
            last_r  <= pick1_s;
            we_r    <= pick1_s ? bus.we1    : bus.we0;
            addr_r  <= pick1_s ? bus.addr1  : bus.addr0;
            din_r   <= pick1_s ? bus.wdata1 : bus.wdata0;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            en_r    <= 1'b0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            we_r    <= 4'h0;
          end
        end
        ACC: begin
          // The lock is not consulted here, so an issued loader access always completes.
          state_r   <= RSP;
          busy_r    <= 1'b1;
          en_r      <= 1'b0;
          gnt0_r    <= 1'b0;
          gnt1_r    <= 1'b0;
          we_r      <= 4'h0;
          rvalid0_r <= ~owner_r & (we_r == 4'h0);
          rvalid1_r <= owner_r & (we_r == 4'h0);
        end
        default: begin
          state_r   <= IDLE;
          busy_r    <= 1'b0;
          en_r      <= 1'b0;
          gnt0_r    <= 1'b0;
          gnt1_r    <= 1'b0;
          rvalid0_r <= 1'b0;
          rvalid1_r <= 1'b0;
          we_r      <= 4'h0;
        end
      endcase
    end
  end

  assign bus.gnt0      = gnt0_r;
  assign bus.gnt1      = gnt1_r;
  assign bus.rvalid0   = rvalid0_r;
  assign bus.rvalid1   = rvalid1_r;
  assign bus.rdata0    = rvalid0_r ? bus.bram_dout : {DW{1'b0}};
  assign bus.rdata1    = rvalid1_r ? bus.bram_dout : {DW{1'b0}};
  assign bus.bram_en   = en_r;
  assign bus.bram_we   = we_r;
  assign bus.bram_addr = addr_r;
  assign bus.bram_din  = din_r;
  assign bus.busy      = busy_r;
endmodule

// File: tb/tb_romcode_bram_arb.sv
// Directed bench for romcode_bram_arb: a round-robin and a fixed-priority instance
// driven with identical stimulus, each attached to its own behavioural BRAM.
module tb_romcode_bram_arb;
  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b0;
  logic        sf_lock;
  logic        req0;
  logic        req1;
  logic [3:0]  we0;
  logic [3:0]  we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  int          checks = 0;
  int          fails  = 0;

  always #5 ap_clk = ~ap_clk;

  romcode_bram_arb_if #(.AW(32), .DW(32)) ifa ();
  romcode_bram_arb_if #(.AW(32), .DW(32)) ifb ();

  assign ifa.sf_lock = sf_lock;
  assign ifa.req0    = req0;
  assign ifa.req1    = req1;
  assign ifa.we0     = we0;
  assign ifa.we1     = we1;
  assign ifa.addr0   = addr0;
  assign ifa.addr1   = addr1;
  assign ifa.wdata0  = wdata0;
  assign ifa.wdata1  = wdata1;
  assign ifb.sf_lock = sf_lock;
  assign ifb.req0    = req0;
  assign ifb.req1    = req1;
  assign ifb.we0     = we0;
  assign ifb.we1     = we1;
  assign ifb.addr0   = addr0;
  assign ifb.addr1   = addr1;
  assign ifb.wdata0  = wdata0;
  assign ifb.wdata1  = wdata1;

  romcode_bram_arb #(.AW(32), .DW(32), .ARB_MODE(0)) dut_a (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(ifa));
  romcode_bram_arb #(.AW(32), .DW(32), .ARB_MODE(1)) dut_b (.ap_clk(ap_clk), .ap_rst(ap_rst), .bus(ifb));

  // Image contents: code word 0x0513 at byte 0x20, a counting pattern elsewhere.
  function automatic logic [31:0] init_word(input int idx);
    if (idx == 8) return 32'h0000_0513;
    return 32'hA500_0000 + 32'(idx);
  endfunction

  // Image after the loader has written 0xDEADBEEF to byte 0x40.
  function automatic logic [31:0] exp_word(input int idx);
    if (idx == 16) return 32'hDEAD_BEEF;
    return init_word(idx);
  endfunction

  // BRAM models, one-cycle read latency, reloaded while reset is held.
  always @(posedge ap_clk) begin
    if (!ap_rst) begin
      for (int i = 0; i < 256; i++) mem_a[i] <= init_word(i);
    end else if (ifa.bram_en) begin
      for (int b = 0; b < 4; b++)
        if (ifa.bram_we[b]) mem_a[ifa.bram_addr[9:2]][8*b +: 8] <= ifa.bram_din[8*b +: 8];
      ifa.bram_dout <= mem_a[ifa.bram_addr[9:2]];
    end
  end

  always @(posedge ap_clk) begin
    if (!ap_rst) begin
      for (int i = 0; i < 256; i++) mem_b[i] <= init_word(i);
    end else if (ifb.bram_en) begin
      for (int b = 0; b < 4; b++)
        if (ifb.bram_we[b]) mem_b[ifb.bram_addr[9:2]][8*b +: 8] <= ifb.bram_din[8*b +: 8];
      ifb.bram_dout <= mem_b[ifb.bram_addr[9:2]];
    end
  end

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0; we0 = 4'h0; we1 = 4'h0;
    addr0 = 32'h0; addr1 = 32'h0; wdata0 = 32'h0; wdata1 = 32'h0;
  endtask

  task automatic test_reset();
    logic [167:0] outs;
    int pulses;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    checks++;
    if ({ifa.busy, ifa.gnt0, ifa.gnt1, ifa.bram_en} !== 4'b0000) begin
      fails++; $display("FAIL reset_state: got %b expected 0000", {ifa.busy, ifa.gnt0, ifa.gnt1, ifa.bram_en});
    end
    req0 = 1'b1; addr0 = 32'h20;
    @(posedge ap_clk); #1;
    checks++;
    if (ifa.bram_en !== 1'b1) begin
      fails++; $display("FAIL reset_pre_acc_en: got %b expected 1", ifa.bram_en);
    end
    ap_rst = 1'b0;
    #1;
    outs = {ifa.gnt0, ifa.gnt1, ifa.rvalid0, ifa.rvalid1, ifa.bram_en, ifa.busy, ifa.bram_we,
            ifa.bram_addr, ifa.bram_din, ifa.rdata0, ifa.rdata1};
    checks++;
    if (outs !== 168'h0) begin
      fails++; $display("FAIL reset_mid_acc_outputs: got %h expected 0", outs);
    end
    req0 = 1'b0;
    @(negedge ap_clk);
    ap_rst = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge ap_clk);
      pulses += int'(ifa.gnt0) + int'(ifa.gnt1) + int'(ifa.rvalid0) + int'(ifa.rvalid1);
    end
    checks++;
    if (pulses !== 0) begin
      fails++; $display("FAIL reset_no_pulses: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_read0();
    req0 = 1'b1; addr0 = 32'h20; we0 = 4'h0;
    @(negedge ap_clk);
    checks++;
    if ({ifa.gnt0, ifa.rvalid0, ifa.bram_en, ifa.bram_addr} !== {3'b101, 32'h20}) begin
      fails++; $display("FAIL read0_gnt: got gnt=%b rv=%b en=%b addr=%h expected 1 0 1 00000020",
                        ifa.gnt0, ifa.rvalid0, ifa.bram_en, ifa.bram_addr);
    end
    req0 = 1'b0;
    @(negedge ap_clk);
    checks++;
    if ({ifa.gnt0, ifa.rvalid0, ifa.bram_en} !== 3'b010 || ifa.rdata0 !== 32'h0000_0513) begin
      fails++; $display("FAIL read0_rvalid: got gnt=%b rv=%b en=%b rdata=%h expected 0 1 0 00000513",
                        ifa.gnt0, ifa.rvalid0, ifa.bram_en, ifa.rdata0);
    end
    @(negedge ap_clk);
    checks++;
    if ({ifa.rvalid0, ifa.busy, ifa.rdata0} !== 34'h0) begin
      fails++; $display("FAIL read0_idle: got rv=%b busy=%b rdata=%h expected 0 0 0",
                        ifa.rvalid0, ifa.busy, ifa.rdata0);
    end
  endtask

  task automatic test_write_read1();
    req1 = 1'b1; addr1 = 32'h40; we1 = 4'hF; wdata1 = 32'hDEAD_BEEF;
    @(negedge ap_clk);
    checks++;
    if ({ifa.gnt1, ifa.bram_we, ifa.bram_din} !== {1'b1, 4'hF, 32'hDEAD_BEEF}) begin
      fails++; $display("FAIL write1_gnt: got gnt=%b we=%h din=%h expected 1 f deadbeef",
                        ifa.gnt1, ifa.bram_we, ifa.bram_din);
    end
    req1 = 1'b0; we1 = 4'h0;
    @(negedge ap_clk);
    checks++;
    if ({ifa.rvalid1, ifa.bram_we, ifa.rdata1} !== 37'h0) begin
      fails++; $display("FAIL write1_no_rvalid: got rv=%b we=%h rdata=%h expected 0 0 0",
                        ifa.rvalid1, ifa.bram_we, ifa.rdata1);
    end
    req1 = 1'b1;
    @(negedge ap_clk);
    checks++;
    if (ifa.gnt1 !== 1'b1) begin
      fails++; $display("FAIL read1_gnt: got %b expected 1", ifa.gnt1);
    end
    req1 = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (ifa.rvalid1 !== 1'b1 || ifa.rdata1 !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL read1_data: got rv=%b rdata=%h expected 1 deadbeef", ifa.rvalid1, ifa.rdata1);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_arbitration();
    logic [15:0] seq_a = 16'h0;
    logic [15:0] seq_b = 16'h0;
    req0 = 1'b1; addr0 = 32'h20; req1 = 1'b1; addr1 = 32'h40;
    for (int c = 0; c < 8; c++) begin
      @(negedge ap_clk);
      seq_a = {seq_a[13:0], ifa.gnt1, ifa.gnt0};
      seq_b = {seq_b[13:0], ifb.gnt1, ifb.gnt0};
    end
    req0 = 1'b0; req1 = 1'b0;
    checks++;
    if (seq_a !== 16'h4848) begin
      fails++; $display("FAIL arb_round_robin: got %h expected 4848", seq_a);
    end
    checks++;
    if (seq_b !== 16'h4444) begin
      fails++; $display("FAIL arb_fixed_priority: got %h expected 4444", seq_b);
    end
    repeat (2) @(negedge ap_clk);
  endtask

  task automatic test_lock();
    int g1 = 0;
    int seen = 0;
    sf_lock = 1'b1; req1 = 1'b1; addr1 = 32'h40;
    repeat (50) begin
      @(negedge ap_clk);
      g1 += int'(ifa.gnt1);
    end
    checks++;
    if (g1 !== 0) begin
      fails++; $display("FAIL lock_blocks_loader: got %0d grants expected 0", g1);
    end
    sf_lock = 1'b0;
    for (int k = 0; k < 2 && seen == 0; k++) begin
      @(negedge ap_clk);
      seen = int'(ifa.gnt1);
    end
    checks++;
    if (seen !== 1) begin
      fails++; $display("FAIL lock_release_gnt: got %0d expected 1", seen);
    end
    req1 = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    req1 = 1'b1; addr1 = 32'h24;
    @(negedge ap_clk);
    checks++;
    if (ifa.gnt1 !== 1'b1) begin
      fails++; $display("FAIL lock_inflight_gnt: got %b expected 1", ifa.gnt1);
    end
    sf_lock = 1'b1; req1 = 1'b0;
    @(negedge ap_clk);
    checks++;
    if (ifa.rvalid1 !== 1'b1 || ifa.rdata1 !== 32'hA500_0009) begin
      fails++; $display("FAIL lock_inflight_completes: got rv=%b rdata=%h expected 1 a5000009",
                        ifa.rvalid1, ifa.rdata1);
    end
    sf_lock = 1'b0;
    @(negedge ap_clk);
  endtask

  task automatic test_back_to_back_stream();
    int loader_gnts = 0;
    int got;
    req1 = 1'b1; addr1 = 32'h80; we1 = 4'h0;
    for (int w = 0; w < 20; w++) begin
      addr0 = 32'h20 + 32'(4 * w); req0 = 1'b1;
      got = 0;
      for (int k = 0; k < 8 && got == 0; k++) begin
        @(negedge ap_clk);
        loader_gnts += int'(ifa.gnt1);
        got = int'(ifa.gnt0);
      end
      req0 = 1'b0;
      if (w == 19) req1 = 1'b0;
      if (got == 0) begin
        checks++; fails++;
        $display("FAIL stream_gnt_timeout: word %0d got no gnt0 within 8 cycles", w);
      end else begin
        @(negedge ap_clk);
        checks++;
        if (ifa.rvalid0 !== 1'b1 || ifa.rdata0 !== exp_word(8 + w)) begin
          fails++; $display("FAIL stream_word_%0d: got rv=%b rdata=%h expected 1 %h",
                            w, ifa.rvalid0, ifa.rdata0, exp_word(8 + w));
        end
      end
    end
    checks++;
    if (loader_gnts !== 19) begin
      fails++; $display("FAIL stream_loader_share: got %0d loader grants expected 19", loader_gnts);
    end
    repeat (2) @(negedge ap_clk);
  endtask

  initial begin
    sf_lock = 1'b0;
    idle_inputs();
    test_reset();
    test_read0();
    test_write_read1();
    test_arbitration();
    test_lock();
    test_back_to_back_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
